// File: rtl/data_memory_responder.sv
// Target end of the datapath load/store port: a level-held req/ack handshake
// with programmable wait states in front of a 2^DATAWIDTH_MEM_ADDR-word RAM.
module data_memory_responder #(
    parameter int DATAWIDTH_BUS      = 32,
    parameter int DATAWIDTH_MEM_ADDR = 8,
    parameter int WAIT_STATES        = 2
) (
    input  logic                     uDataMemory_CLOCK_50,
    input  logic                     uDataMemory_Reset_InLow,
    input  logic                     uDataMemory_Req_In,
    input  logic                     uDataMemory_Write_In,
    input  logic [DATAWIDTH_BUS-1:0] uDataMemory_Address_In,
    input  logic [DATAWIDTH_BUS-1:0] uDataMemory_Data_In,
    output logic [DATAWIDTH_BUS-1:0] uDataMemory_Data_Out,
    output logic                     uDataMemory_Selector_Out,
    output logic                     uDataMemory_Ack_Out,
    output logic                     uDataMemory_Error_Out,
    output logic                     uDataMemory_Busy_Out
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam int         DEPTH     = 1 << DATAWIDTH_MEM_ADDR;

    // Rejects misaligned words and any address bit above the RAM's index range.
    function automatic logic addr_error(input logic [DATAWIDTH_BUS-1:0] addr);
        logic [DATAWIDTH_BUS-1:0] high_bits;
        high_bits = addr >> (DATAWIDTH_MEM_ADDR + 2);
        return (addr[1:0] != 2'b00) || (high_bits != {DATAWIDTH_BUS{1'b0}});
    endfunction

    logic [1:0]                      state_r;
    logic [1:0]                      state_nx_s;
    logic [3:0]                      wcnt_r;
    logic [3:0]                      wcnt_nx_s;
    logic                            capture_s;
    logic                            access_s;
    logic                            write_r;
    logic                            err_r;
    logic [DATAWIDTH_MEM_ADDR-1:0]   idx_r;
    logic [DATAWIDTH_BUS-1:0]        wdata_r;
    logic [DATAWIDTH_BUS-1:0]        dout_r;
    logic                            sel_r;
    logic                            ack_r;
    logic                            error_r;
    logic                            busy_r;
    logic [DATAWIDTH_BUS-1:0]        mem_r [0:DEPTH-1];

    // Next-state and wait-counter logic. A rejected request takes the WAIT
    // path with a zero count so its Ack lands one edge after capture.
    always_comb begin
        state_nx_s = state_r;
        wcnt_nx_s  = wcnt_r;
        capture_s  = 1'b0;
        access_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (uDataMemory_Req_In) begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_WAIT;
                    wcnt_nx_s  = addr_error(uDataMemory_Address_In) ? 4'd0 : WAIT_INIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wcnt_r != 4'd0) begin
                    wcnt_nx_s = wcnt_r - 4'd1;
                end else begin
                    access_s   = 1'b1;
                    state_nx_s = ST_ACK;
                end
            end
            ST_ACK: begin
                state_nx_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!uDataMemory_Req_In) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RELEASE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                wcnt_nx_s  = 4'd0;
            end
        endcase
    end

    // State, counter and request capture; later bus changes are ignored.
    always_ff @(posedge uDataMemory_CLOCK_50 or negedge uDataMemory_Reset_InLow) begin
        if (!uDataMemory_Reset_InLow) begin
            state_r <= ST_IDLE;
            wcnt_r  <= 4'd0;
            write_r <= 1'b0;
            err_r   <= 1'b0;
            idx_r   <= {DATAWIDTH_MEM_ADDR{1'b0}};
            wdata_r <= {DATAWIDTH_BUS{1'b0}};
        end else begin
            state_r <= state_nx_s;
            wcnt_r  <= wcnt_nx_s;
            if (capture_s) begin
                write_r <= uDataMemory_Write_In;
                err_r   <= addr_error(uDataMemory_Address_In);
                idx_r   <= uDataMemory_Address_In[DATAWIDTH_MEM_ADDR+1:2];
                wdata_r <= uDataMemory_Data_In;
            end
        end
    end

    // Registered handshake outputs and load data.
    always_ff @(posedge uDataMemory_CLOCK_50 or negedge uDataMemory_Reset_InLow) begin
        if (!uDataMemory_Reset_InLow) begin
            dout_r  <= {DATAWIDTH_BUS{1'b0}};
            sel_r   <= 1'b0;
            ack_r   <= 1'b0;
            error_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
            if (access_s) begin
                ack_r   <= 1'b1;
                error_r <= err_r;
                sel_r   <= !write_r && !err_r;
                if (err_r) begin
                    dout_r <= {DATAWIDTH_BUS{1'b0}};
                end else if (!write_r) begin
                    dout_r <= mem_r[idx_r];
                end
            end else if (state_r == ST_ACK) begin
                ack_r   <= 1'b0;
                sel_r   <= 1'b0;
                error_r <= 1'b0;
            end
        end
    end

    // RAM array: not reset, so only a committed store ever changes it.
    always_ff @(posedge uDataMemory_CLOCK_50) begin
        if (access_s && write_r && !err_r) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

    assign uDataMemory_Data_Out     = dout_r;
    assign uDataMemory_Selector_Out = sel_r;
    assign uDataMemory_Ack_Out      = ack_r;
    assign uDataMemory_Error_Out    = error_r;
    assign uDataMemory_Busy_Out     = busy_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: three instances with
// WAIT_STATES 2, 0 and 15 share the clock, reset and bus lines.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [3];
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout  [3];
    logic        sel   [3];
    logic        ack   [3];
    logic        err   [3];
    logic        busy  [3];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        sel;
        logic        err;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] mem_m  [3][256];
    logic [31:0] last_m [3];

    always #5 clk = ~clk;

    data_memory_responder #(.WAIT_STATES(2)) dut0 (
        .uDataMemory_CLOCK_50(clk), .uDataMemory_Reset_InLow(rst_n),
        .uDataMemory_Req_In(req[0]), .uDataMemory_Write_In(write),
        .uDataMemory_Address_In(addr), .uDataMemory_Data_In(wdata),
        .uDataMemory_Data_Out(dout[0]), .uDataMemory_Selector_Out(sel[0]),
        .uDataMemory_Ack_Out(ack[0]), .uDataMemory_Error_Out(err[0]),
        .uDataMemory_Busy_Out(busy[0]));

    data_memory_responder #(.WAIT_STATES(0)) dut1 (
        .uDataMemory_CLOCK_50(clk), .uDataMemory_Reset_InLow(rst_n),
        .uDataMemory_Req_In(req[1]), .uDataMemory_Write_In(write),
        .uDataMemory_Address_In(addr), .uDataMemory_Data_In(wdata),
        .uDataMemory_Data_Out(dout[1]), .uDataMemory_Selector_Out(sel[1]),
        .uDataMemory_Ack_Out(ack[1]), .uDataMemory_Error_Out(err[1]),
        .uDataMemory_Busy_Out(busy[1]));

    data_memory_responder #(.WAIT_STATES(15)) dut2 (
        .uDataMemory_CLOCK_50(clk), .uDataMemory_Reset_InLow(rst_n),
        .uDataMemory_Req_In(req[2]), .uDataMemory_Write_In(write),
        .uDataMemory_Address_In(addr), .uDataMemory_Data_In(wdata),
        .uDataMemory_Data_Out(dout[2]), .uDataMemory_Selector_Out(sel[2]),
        .uDataMemory_Ack_Out(ack[2]), .uDataMemory_Error_Out(err[2]),
        .uDataMemory_Busy_Out(busy[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    endfunction

    // One full transaction on instance k, checking latency, Ack-cycle values,
    // the single-pulse Ack, Busy, and release once Req drops.
    task automatic txn(input int k, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int ws, input int hold);
        exp_t e;
        exp_t o;
        int   n;
        int   extra;
        logic is_err;
        logic got_ack;
        is_err = bad_addr(a);
        if (is_err) begin
            e.data = 32'h0; e.sel = 1'b0; e.err = 1'b1;
            last_m[k] = 32'h0;
        end else if (wr) begin
            mem_m[k][a[9:2]] = d;
            e.data = last_m[k]; e.sel = 1'b0; e.err = 1'b0;
        end else begin
            e.data = mem_m[k][a[9:2]]; e.sel = 1'b1; e.err = 1'b0;
            last_m[k] = e.data;
        end
        sb_q.push_back(e);

        @(negedge clk);
        req[k] = 1'b1; write = wr; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        write = ~wr; addr = a ^ 32'h0000_0FF0; wdata = ~d;

        n = 0;
        got_ack = 1'b0;
        while (!got_ack && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack[k]) begin
                got_ack = 1'b1;
            end else begin
                check_eq("busy_wait", 32'(busy[k]), 32'd1);
                check_eq("sel_wait", 32'(sel[k]), 32'd0);
            end
        end
        check_eq("ack_latency", 32'(n), is_err ? 32'd1 : 32'(ws + 1));
        o = sb_q.pop_front();
        if (got_ack) begin
            check_eq("ack_data", dout[k], o.data);
            check_eq("ack_sel", 32'(sel[k]), 32'(o.sel));
            check_eq("ack_err", 32'(err[k]), 32'(o.err));
            check_eq("ack_busy", 32'(busy[k]), 32'd1);
        end

        @(posedge clk); #1;
        check_eq("post_ack", 32'(ack[k]), 32'd0);
        check_eq("post_sel", 32'(sel[k]), 32'd0);
        check_eq("post_err", 32'(err[k]), 32'd0);
        check_eq("post_busy", 32'(busy[k]), 32'd1);

        extra = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (ack[k]) extra++;
            check_eq("hold_busy", 32'(busy[k]), 32'd1);
        end
        if (hold > 0) check_eq("hold_extra_ack", 32'(extra), 32'd0);

        @(negedge clk);
        req[k] = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_busy", 32'(busy[k]), 32'd0);
        check_eq("dout_hold", dout[k], last_m[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0;
            last_m[i] = 32'h0;
        end
        write = 1'b0; addr = 32'h0; wdata = 32'h0;

        #12;
        check_eq("rst_dout", dout[0], 32'h0);
        check_eq("rst_sel", 32'(sel[0]), 32'd0);
        check_eq("rst_ack", 32'(ack[0]), 32'd0);
        check_eq("rst_err", 32'(err[0]), 32'd0);
        check_eq("rst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // store/load round trip
        txn(0, 1'b1, 32'h010, 32'hDEADBEEF, 2, 0);
        txn(0, 1'b0, 32'h010, 32'h0, 2, 0);

        // rejected requests
        txn(0, 1'b0, 32'h013, 32'h0, 2, 0);
        txn(0, 1'b1, 32'h400, 32'h5555_5555, 2, 0);
        txn(0, 1'b0, 32'h010, 32'h0, 2, 0);

        // wait-state sweep
        txn(1, 1'b1, 32'h040, 32'h0BADF00D, 0, 0);
        txn(1, 1'b0, 32'h040, 32'h0, 0, 0);
        txn(1, 1'b0, 32'h041, 32'h0, 0, 0);
        txn(2, 1'b1, 32'h3FC, 32'hFEEDFACE, 15, 0);
        txn(2, 1'b0, 32'h3FC, 32'h0, 15, 0);

        // Req held across Ack, then a fresh transaction
        txn(0, 1'b0, 32'h010, 32'h0, 2, 10);
        txn(0, 1'b1, 32'h014, 32'h600DCAFE, 2, 0);
        txn(0, 1'b0, 32'h014, 32'h0, 2, 0);

        // reset during WAIT discards the pending store
        txn(0, 1'b1, 32'h020, 32'hAAAAAAAA, 2, 0);
        txn(0, 1'b0, 32'h010, 32'h0, 2, 0);
        @(negedge clk);
        req[0] = 1'b1; write = 1'b1; addr = 32'h020; wdata = 32'h12345678;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_dout", dout[0], 32'h0);
        check_eq("arst_sel", 32'(sel[0]), 32'd0);
        check_eq("arst_ack", 32'(ack[0]), 32'd0);
        check_eq("arst_err", 32'(err[0]), 32'd0);
        check_eq("arst_busy", 32'(busy[0]), 32'd0);
        req[0] = 1'b0;
        for (int i = 0; i < 3; i++) last_m[i] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 1'b0, 32'h020, 32'h0, 2, 0);

        // back-to-back stores then loads
        for (int i = 0; i < 4; i++) txn(0, 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i * 17), 2, 0);
        for (int i = 0; i < 4; i++) txn(0, 1'b0, 32'(i * 4), 32'h0, 2, 0);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
